// File: rtl/bus_arbiter_16_pkg.sv
// Shared definitions for the 16-way round-robin bus arbiter.
package bus_arbiter_16_pkg;

    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // One-hot grant vector for a given owner index.
    function automatic logic [N_REQ-1:0] onehot16(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_16_rr_pick16.sv
// Combinational round-robin picker: finds the first set request bit
// searching upward from ptr, wrapping from 15 back to 0.
module rr_pick16
    import bus_arbiter_16_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] win
);

    logic [N_REQ-1:0] rotated;
    logic [SEL_W-1:0] offset;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then undo the rotation.
    always_comb begin
        rotated = N_REQ'({req, req} >> ptr);
        offset  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = SEL_W'(i);
            end
        end
        any = |req;
        win = offset + ptr;
    end

endmodule

// File: rtl/bus_arbiter_16.sv
// Round-robin arbiter for the shared 16-way operand/result bus.
// All outputs are registered; a tenure ends when the owner drops its
// request or after MAX_HOLD accepted beats, and one idle cycle always
// separates consecutive tenures.
module bus_arbiter_16
    import bus_arbiter_16_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             ack,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] grant,
    output logic             valid,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_HOLD - 1);

    state_t           state;
    state_t           state_nx;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_nx;
    logic [SEL_W-1:0] sel_nx;
    logic [N_REQ-1:0] grant_nx;
    logic             valid_nx;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_nx;
    logic             rel;
    logic             pick_any;
    logic [SEL_W-1:0] pick_win;

    rr_pick16 u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .win (pick_win)
    );

    // Next-state logic: arbitrate from IDLE, count beats and decide release in GRANT.
    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        sel_nx      = sel;
        grant_nx    = grant;
        valid_nx    = valid;
        hold_cnt_nx = hold_cnt;
        rel         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nx    = ST_GRANT;
                    sel_nx      = pick_win;
                    grant_nx    = onehot16(pick_win);
                    valid_nx    = 1'b1;
                    hold_cnt_nx = '0;
                end
            end
            ST_GRANT: begin
                rel = !req[sel] || (ack && (hold_cnt == LAST_BEAT));
                if (rel) begin
                    state_nx    = ST_IDLE;
                    grant_nx    = '0;
                    valid_nx    = 1'b0;
                    hold_cnt_nx = '0;
                    ptr_nx      = sel + SEL_W'(1);
                end else if (ack) begin
                    hold_cnt_nx = hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx    = ST_IDLE;
                grant_nx    = '0;
                valid_nx    = 1'b0;
                hold_cnt_nx = '0;
            end
        endcase
    end

    // State, pointer, counter and output registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            sel      <= '0;
            grant    <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            sel      <= sel_nx;
            grant    <= grant_nx;
            valid    <= valid_nx;
            busy     <= valid_nx;
            hold_cnt <= hold_cnt_nx;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_16.sv
// Bench for bus_arbiter_16: dut1 runs with MAX_HOLD=4, dut2 with MAX_HOLD=2.
module tb_bus_arbiter_16;

    logic        clk;
    logic        rst;
    logic [15:0] req1;
    logic        ack1;
    logic [3:0]  sel1;
    logic [15:0] grant1;
    logic        valid1;
    logic        busy1;
    logic [15:0] req2;
    logic        ack2;
    logic [3:0]  sel2;
    logic [15:0] grant2;
    logic        valid2;
    logic        busy2;

    int nChecks = 0;
    int nPass   = 0;

    logic [3:0] expQ1[$];
    logic [3:0] expQ2[$];

    bus_arbiter_16 #(.MAX_HOLD(4), .CNT_W(8)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .req   (req1),
        .ack   (ack1),
        .sel   (sel1),
        .grant (grant1),
        .valid (valid1),
        .busy  (busy1)
    );

    bus_arbiter_16 #(.MAX_HOLD(2), .CNT_W(8)) dut2 (
        .clk   (clk),
        .rst   (rst),
        .req   (req2),
        .ack   (ack2),
        .sel   (sel2),
        .grant (grant2),
        .valid (valid2),
        .busy  (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int unit, input logic [15:0] r, input logic a);
        @(posedge clk);
        #1;
        if (unit == 1) begin
            req1 = r;
            ack1 = a;
        end else begin
            req2 = r;
            ack2 = a;
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic pushOwner(input int unit, input logic [3:0] owner, input int n);
        for (int i = 0; i < n; i++) begin
            if (unit == 1) expQ1.push_back(owner);
            else           expQ2.push_back(owner);
        end
    endtask

    // Every valid cycle of dut1 must match the next expected owner.
    always @(negedge clk) begin
        logic [3:0] o;
        if (valid1) begin
            if (expQ1.size() == 0) begin
                nChecks++;
                $display("[TB] FAIL dut1 unexpected valid: sel=%0d grant=%h, required no valid", sel1, grant1);
            end else begin
                o = expQ1.pop_front();
                checkOutput("dut1 sel", 32'(sel1), 32'(o));
                checkOutput("dut1 grant", 32'(grant1), 32'(16'h0001 << o));
                checkOutput("dut1 busy", 32'(busy1), 32'd1);
            end
        end else begin
            checkOutput("dut1 idle grant", 32'(grant1), 32'd0);
            checkOutput("dut1 idle busy", 32'(busy1), 32'd0);
        end
    end

    // Same scoreboard for dut2.
    always @(negedge clk) begin
        logic [3:0] o;
        if (valid2) begin
            if (expQ2.size() == 0) begin
                nChecks++;
                $display("[TB] FAIL dut2 unexpected valid: sel=%0d grant=%h, required no valid", sel2, grant2);
            end else begin
                o = expQ2.pop_front();
                checkOutput("dut2 sel", 32'(sel2), 32'(o));
                checkOutput("dut2 grant", 32'(grant2), 32'(16'h0001 << o));
            end
        end else begin
            checkOutput("dut2 idle grant", 32'(grant2), 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst  = 1'b1;
        req1 = '0;
        ack1 = 1'b0;
        req2 = '0;
        ack2 = 1'b0;

        // Reset values.
        @(negedge clk);
        checkOutput("reset grant", 32'(grant1), 32'd0);
        checkOutput("reset sel", 32'(sel1), 32'd0);
        checkOutput("reset valid", 32'(valid1), 32'd0);
        checkOutput("reset busy", 32'(busy1), 32'd0);
        checkOutput("reset ptr", 32'(dut1.ptr), 32'd0);
        checkOutput("reset hold_cnt", 32'(dut1.hold_cnt), 32'd0);
        #1 rst = 1'b0;

        // Full round robin on dut2: owners 0..15 then 0, two beats each.
        $display("[TB] round robin, MAX_HOLD=2");
        for (int k = 0; k < 17; k++) pushOwner(2, 4'(k % 16), 2);
        applyStimulus(2, 16'hFFFF, 1'b1);
        waitCycles(50);
        applyStimulus(2, 16'h0000, 1'b0);
        @(negedge clk);
        checkOutput("rr final ptr", 32'(dut2.ptr), 32'd1);

        // ack in IDLE with no requests is ignored.
        $display("[TB] ignored ack");
        applyStimulus(1, 16'h0000, 1'b1);
        waitCycles(3);
        @(negedge clk);
        checkOutput("ignored ack valid", 32'(valid1), 32'd0);
        checkOutput("ignored ack hold_cnt", 32'(dut1.hold_cnt), 32'd0);
        applyStimulus(1, 16'h0000, 1'b0);

        // Owner 13 released early sets ptr=14; then 15, 0, 1 win in turn.
        $display("[TB] wrap and priority");
        pushOwner(1, 4'd13, 3);
        applyStimulus(1, 16'h2000, 1'b0);
        waitCycles(2);
        applyStimulus(1, 16'h0000, 1'b0);
        pushOwner(1, 4'd15, 4);
        pushOwner(1, 4'd0, 4);
        pushOwner(1, 4'd1, 4);
        applyStimulus(1, 16'h8003, 1'b1);
        waitCycles(14);
        applyStimulus(1, 16'h0000, 1'b0);
        @(negedge clk);
        checkOutput("wrap final ptr", 32'(dut1.ptr), 32'd2);

        // Owner 3 takes one beat, then drops req with ack=0.
        $display("[TB] early release");
        pushOwner(1, 4'd3, 2);
        applyStimulus(1, 16'h0008, 1'b0);
        applyStimulus(1, 16'h0008, 1'b1);
        applyStimulus(1, 16'h0000, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("early ptr", 32'(dut1.ptr), 32'd4);
        checkOutput("early hold_cnt", 32'(dut1.hold_cnt), 32'd0);
        checkOutput("early sel held", 32'(sel1), 32'd3);

        // Owner 7: three beats, then fourth beat together with req falling.
        $display("[TB] simultaneous drop and final beat");
        pushOwner(1, 4'd7, 4);
        applyStimulus(1, 16'h0080, 1'b0);
        applyStimulus(1, 16'h0080, 1'b1);
        waitCycles(2);
        @(negedge clk);
        checkOutput("simul hold_cnt 2", 32'(dut1.hold_cnt), 32'd2);
        applyStimulus(1, 16'h0000, 1'b1);
        @(negedge clk);
        checkOutput("simul hold_cnt 3", 32'(dut1.hold_cnt), 32'd3);
        checkOutput("simul valid", 32'(valid1), 32'd1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("simul ptr", 32'(dut1.ptr), 32'd8);
        checkOutput("simul hold_cnt 0", 32'(dut1.hold_cnt), 32'd0);
        checkOutput("simul valid off", 32'(valid1), 32'd0);

        // No ack for 50+ cycles: owner 7 keeps the bus.
        $display("[TB] no ack, held grant");
        pushOwner(1, 4'd7, 51);
        applyStimulus(1, 16'h0080, 1'b0);
        waitCycles(50);
        applyStimulus(1, 16'h0000, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("held ptr", 32'(dut1.ptr), 32'd8);

        // Non-owner requests toggle while owner 8 holds.
        $display("[TB] non-owner toggling");
        pushOwner(1, 4'd8, 5);
        applyStimulus(1, 16'h0100, 1'b0);
        applyStimulus(1, 16'hFFFF, 1'b0);
        applyStimulus(1, 16'h0180, 1'b0);
        applyStimulus(1, 16'h0300, 1'b0);
        applyStimulus(1, 16'h7F7F, 1'b0);
        applyStimulus(1, 16'h0000, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("toggle ptr", 32'(dut1.ptr), 32'd9);

        // Reset mid-tenure: owner 5 at hold_cnt=3.
        $display("[TB] reset mid-tenure");
        pushOwner(1, 4'd5, 4);
        applyStimulus(1, 16'h0020, 1'b0);
        applyStimulus(1, 16'h0020, 1'b1);
        waitCycles(2);
        applyStimulus(1, 16'h0020, 1'b0);
        @(negedge clk);
        checkOutput("pre-reset hold_cnt", 32'(dut1.hold_cnt), 32'd3);
        #2 rst = 1'b1;
        #1;
        checkOutput("async reset grant", 32'(grant1), 32'd0);
        checkOutput("async reset valid", 32'(valid1), 32'd0);
        checkOutput("async reset sel", 32'(sel1), 32'd0);
        checkOutput("async reset busy", 32'(busy1), 32'd0);
        checkOutput("async reset ptr", 32'(dut1.ptr), 32'd0);
        @(posedge clk);
        @(negedge clk);
        pushOwner(1, 4'd5, 2);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset grant", 32'(grant1), 32'h0020);
        applyStimulus(1, 16'h0000, 1'b0);

        // Sole requester is re-granted after the idle bubble.
        $display("[TB] sole requester");
        pushOwner(1, 4'd2, 8);
        applyStimulus(1, 16'h0004, 1'b1);
        waitCycles(9);
        applyStimulus(1, 16'h0000, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("sole ptr", 32'(dut1.ptr), 32'd3);

        waitCycles(3);
        @(negedge clk);
        checkOutput("dut1 expected queue drained", 32'(expQ1.size()), 32'd0);
        checkOutput("dut2 expected queue drained", 32'(expQ2.size()), 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_16.md
Name: bus_arbiter_16

Overview:
- Round-robin arbiter that shares the 16-way, 16-bit operand/result bus among 16 requesters.
- Drives the 4-bit select of the downstream 16:1 bus mux and a one-hot grant back to the requesters.
- Caps each tenure at MAX_HOLD accepted beats so no requester can starve the others.
- Sits between the requester ports and the bus mux in the processor datapath.

Parameters:
- MAX_HOLD, 8, maximum beats (acks) per grant tenure; legal range 1..255.
- CNT_W, 8, width of the beat counter; must hold MAX_HOLD-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  16  request vector; bit i = requester i wants the bus, held high for the whole transfer.
- ack  input  1  consumer accepted the current bus word this cycle; ignored unless valid=1.
- sel  output  4  mux select, equal to the index of the current owner.
- grant  output  16  one-hot owner indication; all zeros when no owner.
- valid  output  1  bus carries the owner's data this cycle.
- busy  output  1  high in GRANT state (identical to valid; kept separate for status reads).

Behaviour:
- Reset (async, rst=1): state=IDLE, sel=0, grant=0, valid=0, busy=0, ptr=0, hold_cnt=0. Asserting reset mid-tenure clears everything immediately, with no completion beat. After release, the first arbitration uses ptr=0.
- All outputs are registered; no combinational path from req or ack to any output.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick winner w = the first set bit of req, searching upward from ptr with wrap 15->0.
  - At the clock edge: sel=w, grant=1<<w, valid=1, hold_cnt=0, go to GRANT.
  - Latency: req sampled at edge n gives grant visible after edge n (one cycle from request to grant).
- GRANT (owner o = sel):
  - Beat: ack=1. hold_cnt increments on each beat.
  - Release condition R = (req[o]==0) OR (ack==1 AND hold_cnt==MAX_HOLD-1).
  - If R: at the edge set grant=0, valid=0, hold_cnt=0, ptr=(o+1) mod 16 (4-bit wrap), go to IDLE. sel holds its last value.
  - Otherwise stay in GRANT with grant/sel unchanged.
- req[o] dropping in the same cycle as ack: the beat counts and the tenure releases.
- req[o] dropping with ack=0: release, no beat.
- req bits of non-owners change freely during GRANT with no effect.
- No timeout: if ack never arrives and req[o] stays high, the grant is held indefinitely.
- One-cycle IDLE bubble between tenures is mandatory; back-to-back re-grant without the bubble is forbidden.
- Sole requester: after release it is re-granted after the bubble (ptr wraps back to it).
- MAX_HOLD=1: release after every beat.
- hold_cnt never exceeds MAX_HOLD-1.
- Invariant: grant is one-hot or zero, and grant!=0 exactly when valid=1.

Decomposition:
- Shared package/header:
  - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
  - N_REQ=16 and SEL_W=4.
- One natural sub-module: rr_pick16, purely combinational.
  - Inputs: req[15:0], ptr[3:0].
  - Outputs: any, win[3:0].
  - Implementation: rotate-right by ptr, priority-encode the lowest set bit, add ptr mod 16.
- The FSM, counter and pointer live in bus_arbiter_16.

Test Plan:
- Reset mid-tenure: owner 5 holding, hold_cnt=3; assert rst asynchronously -> grant=0, valid=0, sel=0 before the next clk edge; after release, req=16'h0020 -> grant=16'h0020 one edge later.
- Round robin: req=16'hFFFF held, ack=1 every cycle, MAX_HOLD=2 -> owners in order 0,1,2,...,15,0, each owning for 2 valid cycles with one idle cycle between.
- Wrap and priority: ptr=14 (previous owner 13), req=16'h0003|16'h8000 -> winner 15; next tenure winner 0, then 1.
- Early release: owner 3, req[3] drops at cycle 2 with ack=0 -> release at that edge, hold_cnt=0, ptr=4, no extra beat counted.
- Simultaneous drop and final beat, MAX_HOLD=4: 3 acks, then a 4th ack coinciding with req[7] falling -> single release, ptr=8. Also: ack held 0 for 50 cycles with req[7] high -> grant=16'h0080 held for all 50 cycles.
- Ignored ack: ack=1 in IDLE with req=0 -> no state change, hold_cnt stays 0. Non-owner req toggling during GRANT -> grant unchanged.
